// File: rtl/instr_fetch_issue_pkg.sv
// Shared definitions for the fetch/issue stage and the control path: opcode
// constants, instruction field positions, fetch FSM encoding, immediate sign extension.
package instr_fetch_issue_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int FIELD_W    = 5;
  localparam int IMM_W      = 17;
  localparam int TARGET_W   = 27;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(32-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit instruction word into its named fields,
// including the sign-extended 17-bit immediate; shared with the control path.
module instr_field_split
  import instr_fetch_issue_pkg::*;
(
  input  logic [31:0]         ir_i,
  output logic [FIELD_W-1:0]  opcode_o,
  output logic [FIELD_W-1:0]  rd_o,
  output logic [FIELD_W-1:0]  rs_o,
  output logic [FIELD_W-1:0]  rt_o,
  output logic [FIELD_W-1:0]  shamt_o,
  output logic [FIELD_W-1:0]  aluop_o,
  output logic [31:0]         imm_o,
  output logic [TARGET_W-1:0] target_o
);

  assign opcode_o = ir_i[OPCODE_LSB +: FIELD_W];
  assign rd_o     = ir_i[RD_LSB     +: FIELD_W];
  assign rs_o     = ir_i[RS_LSB     +: FIELD_W];
  assign rt_o     = ir_i[RT_LSB     +: FIELD_W];
  assign shamt_o  = ir_i[SHAMT_LSB  +: FIELD_W];
  assign aluop_o  = ir_i[ALUOP_LSB  +: FIELD_W];
  assign imm_o    = sext_imm(ir_i[IMM_W-1:0]);
  assign target_o = ir_i[TARGET_W-1:0];

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue stage: owns the PC, keeps one imem request outstanding, presents split
// fields over valid/ready. Define FETCH_PERF_CNT_EN to add perf_issued/perf_squashed.
module instr_fetch_issue
  import instr_fetch_issue_pkg::*;
#(
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [AW-1:0] issue_pc,
  output logic [4:0]    opcode,
  output logic [4:0]    rd,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    shamt,
  output logic [4:0]    aluop,
  output logic [31:0]   imm,
  output logic [26:0]   target,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_issued,
  output logic [31:0]   perf_squashed
`endif
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] issue_pc_q, issue_pc_d;
  logic [31:0]   ir_q, ir_d;
  logic          drop_q, drop_d;
  logic          handshake;
  logic          squash;

  always_comb begin
    state_d    = state_q;
    pc_d       = redirect_valid ? redirect_pc : pc_q;
    issue_pc_d = issue_pc_q;
    ir_d       = ir_q;
    drop_d     = drop_q;
    handshake  = 1'b0;
    squash     = 1'b0;
    case (state_q)
      ST_REQ: begin
        // The request to the old PC still goes out; a redirect only marks it stale.
        issue_pc_d = pc_q;
        if (!redirect_valid) pc_d = pc_q + AW'(1);
        drop_d     = redirect_valid;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            squash  = 1'b1;
            state_d = ST_REQ;
          end else begin
            ir_d    = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // A handshake in the redirect cycle still counts as issued.
        if (issue_ready) begin
          handshake = 1'b1;
          state_d   = ST_REQ;
        end else if (redirect_valid) begin
          squash  = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      ir_q       <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      ir_q       <= ir_d;
      drop_q     <= drop_d;
    end
  end

  assign imem_req    = reset_n && (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign issue_valid = reset_n && (state_q == ST_HOLD);
  assign issue_pc    = issue_pc_q;

  instr_field_split u_split (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .rd_o     (rd),
    .rs_o     (rs),
    .rt_o     (rt),
    .shamt_o  (shamt),
    .aluop_o  (aluop),
    .imm_o    (imm),
    .target_o (target)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_squashed_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_issued_q   <= '0;
      perf_squashed_q <= '0;
    end else begin
      if (handshake) perf_issued_q   <= perf_issued_q + 32'd1;
      if (squash)    perf_squashed_q <= perf_squashed_q + 32'd1;
    end
  end

  assign perf_issued   = perf_issued_q;
  assign perf_squashed = perf_squashed_q;
`else
  logic unused_perf;
  assign unused_perf = handshake ^ squash;
`endif

endmodule
